// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch-stage state encoding, PC step and default widths.
package mips_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int INST_W_DEF = 32;
    localparam int PC_INC     = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to a wait-state instruction memory and
// buffers one instruction for decode. MIPS_FETCH_ALIGN_CHECK_EN rejects misaligned redirects.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] inst_pc4,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              misaligned
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_INC);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [ADDR_W-1:0] tgt, tgt_next;
    logic              load_buf;
    logic              redir_ok;
    logic [ADDR_W-1:0] redir_tgt;

`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    logic misaligned_q;

    assign redir_ok  = redirect && (redirect_pc[1:0] == 2'b00);
    assign redir_tgt = redirect_pc;

    always_ff @(posedge clk) begin
        if (reset) misaligned_q <= 1'b0;
        else       misaligned_q <= redirect && (redirect_pc[1:0] != 2'b00);
    end

    assign misaligned = misaligned_q;
`else
    logic unused_redirect_low;

    assign redir_ok            = redirect;
    assign redir_tgt           = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_low = ^redirect_pc[1:0];
    assign misaligned          = 1'b0;
`endif

    // The request never depends on this cycle's inputs, so an open request cannot be retracted.
    assign imem_req   = !reset && (state != HOLD);
    assign imem_addr  = pc;
    assign inst_valid = (state == HOLD);
    assign inst_pc4   = inst_pc + STEP;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        tgt_next   = tgt;
        load_buf   = 1'b0;
        case (state)
            FETCH: begin
                if (imem_ack && !redir_ok) begin
                    load_buf   = 1'b1;
                    pc_next    = pc + STEP;
                    state_next = HOLD;
                end else if (imem_ack) begin
                    pc_next = redir_tgt;
                end else if (redir_ok) begin
                    tgt_next   = redir_tgt;
                    state_next = DROP;
                end
            end
            HOLD: begin
                if (redir_ok) begin
                    pc_next    = redir_tgt;
                    state_next = FETCH;
                end else if (inst_ready) begin
                    state_next = FETCH;
                end
            end
            DROP: begin
                // Stale request still open: newest redirect target wins once it completes.
                if (redir_ok) tgt_next = redir_tgt;
                if (imem_ack) begin
                    pc_next    = redir_ok ? redir_tgt : tgt;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            pc      <= {RESET_PC[ADDR_W-1:2], 2'b00};
            tgt     <= '0;
            inst    <= '0;
            inst_pc <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            tgt   <= tgt_next;
            if (load_buf) begin
                inst    <= imem_rdata;
                inst_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed vector table, hand-written corner
// sequences and randomized traffic against a transaction-level model.
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    mips_fetch_unit #(
        .ADDR_W  (32),
        .INST_W  (32),
        .RESET_PC(32'h0000_0100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_pc4   (inst_pc4),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ack;
        logic [31:0] rdata;
        bit          ready;
        bit          redir;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        bit          e_mis;
    } vec_t;

    vec_t vecs[19];

    // Transaction-level view: a buffered instruction, an abandoned request awaiting its ack,
    // and the address the memory is being (or will next be) asked for.
    bit          m_buf_valid;
    logic [31:0] m_inst;
    logic [31:0] m_inst_pc;
    logic [31:0] m_fetch_pc;
    bit          m_pending;
    logic [31:0] m_pending_tgt;
    bit          m_mis;

    task automatic applyStimulus(input bit ack, input logic [31:0] rdata, input bit ready,
                                 input bit redir, input logic [31:0] rpc);
        imem_ack    = ack;
        imem_rdata  = rdata;
        inst_ready  = ready;
        redirect    = redir;
        redirect_pc = rpc;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag, input bit e_req, input logic [31:0] e_addr,
                            input bit e_valid, input logic [31:0] e_inst,
                            input logic [31:0] e_pc, input bit e_mis);
        logic [31:0] e_pc4;
        e_pc4 = e_pc + 32'd4;
        checkOutput({tag, ".req"}, 64'(imem_req), 64'(e_req));
        if (e_req) checkOutput({tag, ".addr"}, 64'(imem_addr), 64'(e_addr));
        checkOutput({tag, ".valid"}, 64'(inst_valid), 64'(e_valid));
        if (e_valid) begin
            checkOutput({tag, ".inst"}, 64'(inst), 64'(e_inst));
            checkOutput({tag, ".inst_pc"}, 64'(inst_pc), 64'(e_pc));
            checkOutput({tag, ".inst_pc4"}, 64'(inst_pc4), 64'(e_pc4));
        end
        checkOutput({tag, ".misaligned"}, 64'(misaligned), 64'(e_mis));
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        checkOutput("reset.req", 64'(imem_req), 64'd0);
        checkOutput("reset.valid", 64'(inst_valid), 64'd0);
        checkOutput("reset.misaligned", 64'(misaligned), 64'd0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic modelStep(input bit ack, input logic [31:0] rdata, input bit ready,
                             input bit redir, input logic [31:0] rpc);
        bit          take;
        logic [31:0] dest;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
        take  = redir && (rpc % 4 == 0);
        dest  = rpc;
        m_mis = redir && (rpc % 4 != 0);
`else
        take  = redir;
        dest  = rpc - (rpc % 4);
        m_mis = 1'b0;
`endif
        if (m_buf_valid) begin
            if (take) begin
                m_buf_valid = 1'b0;
                m_fetch_pc  = dest;
            end else if (ready) begin
                m_buf_valid = 1'b0;
            end
        end else if (m_pending) begin
            if (take) m_pending_tgt = dest;
            if (ack) begin
                m_pending  = 1'b0;
                m_fetch_pc = m_pending_tgt;
            end
        end else if (ack) begin
            if (take) begin
                m_fetch_pc = dest;
            end else begin
                m_buf_valid = 1'b1;
                m_inst      = rdata;
                m_inst_pc   = m_fetch_pc;
                m_fetch_pc  = m_fetch_pc + 32'd4;
            end
        end else if (take) begin
            m_pending     = 1'b1;
            m_pending_tgt = dest;
        end
    endtask

    initial begin
        logic [31:0] held_inst;
        logic [31:0] held_pc;
        logic [31:0] rp;
        bit          a, r, d;

`ifdef MIPS_FETCH_ALIGN_CHECK_EN
        localparam logic [31:0] AFTER_BAD = 32'h0000_0304;
        localparam bit          BAD_MIS   = 1'b1;
`else
        localparam logic [31:0] AFTER_BAD = 32'h0000_0400;
        localparam bit          BAD_MIS   = 1'b0;
`endif
        //           ack rdata          rdy red rpc            req addr           val inst          pc             mis
        vecs[0]  = '{1, 32'hA000_0000, 0, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h0,         32'h0,         0};
        vecs[1]  = '{0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'hA000_0000, 32'h0000_0100, 0};
        vecs[2]  = '{1, 32'hA111_1111, 0, 0, 32'h0,         1, 32'h0000_0104, 0, 32'h0,         32'h0,         0};
        vecs[3]  = '{0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'hA111_1111, 32'h0000_0104, 0};
        vecs[4]  = '{0, 32'h0,         0, 1, 32'h0000_0400, 1, 32'h0000_0108, 0, 32'h0,         32'h0,         0};
        vecs[5]  = '{0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0108, 0, 32'h0,         32'h0,         0};
        vecs[6]  = '{1, 32'hDEAD_BEEF, 0, 0, 32'h0,         1, 32'h0000_0108, 0, 32'h0,         32'h0,         0};
        vecs[7]  = '{1, 32'hB000_0000, 0, 0, 32'h0,         1, 32'h0000_0400, 0, 32'h0,         32'h0,         0};
        vecs[8]  = '{0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'hB000_0000, 32'h0000_0400, 0};
        vecs[9]  = '{0, 32'h0,         1, 1, 32'h0000_0500, 0, 32'h0,         1, 32'hB000_0000, 32'h0000_0400, 0};
        vecs[10] = '{0, 32'h0,         0, 1, 32'h0000_0200, 1, 32'h0000_0500, 0, 32'h0,         32'h0,         0};
        vecs[11] = '{0, 32'h0,         0, 1, 32'h0000_0300, 1, 32'h0000_0500, 0, 32'h0,         32'h0,         0};
        vecs[12] = '{1, 32'hBAD0_BAD0, 0, 0, 32'h0,         1, 32'h0000_0500, 0, 32'h0,         32'h0,         0};
        vecs[13] = '{1, 32'hC000_0000, 0, 0, 32'h0,         1, 32'h0000_0300, 0, 32'h0,         32'h0,         0};
        vecs[14] = '{0, 32'h0,         1, 1, 32'h0000_0402, 0, 32'h0,         1, 32'hC000_0000, 32'h0000_0300, 0};
        vecs[15] = '{1, 32'h1234_5678, 0, 1, 32'hFFFF_FFFC, 1, AFTER_BAD,     0, 32'h0,         32'h0,         BAD_MIS};
        vecs[16] = '{1, 32'hD000_0000, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         0};
        vecs[17] = '{0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'hD000_0000, 32'hFFFF_FFFC, 0};
        vecs[18] = '{0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0,         32'h0,         0};

        doReset();

        for (int i = 0; i < 19; i++) begin
            checkAll($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                     vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_mis);
            applyStimulus(vecs[i].ack, vecs[i].rdata, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
            @(negedge clk);
        end

        // Three wait-states at address 0, then decode stalls for five cycles.
        for (int i = 0; i < 3; i++) begin
            checkAll("wait", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
        end
        checkAll("wait.ack", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'hE000_0000, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        held_inst = 32'hE000_0000;
        held_pc   = 32'h0;
        for (int i = 0; i < 5; i++) begin
            checkAll("stall", 1'b0, 32'h0, 1'b1, held_inst, held_pc, 1'b0);
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
        end
        checkAll("stall.release", 1'b0, 32'h0, 1'b1, held_inst, held_pc, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkAll("after.stall", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);

        // Abandon an outstanding request with reset; fetch restarts at the reset PC.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0600);
        @(negedge clk);
        checkAll("drop.pre_reset", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);
        doReset();
        checkAll("post_reset", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);

        m_buf_valid   = 1'b0;
        m_pending     = 1'b0;
        m_fetch_pc    = 32'h100;
        m_pending_tgt = 32'h0;
        m_inst        = 32'h0;
        m_inst_pc     = 32'h0;
        m_mis         = 1'b0;
        for (int i = 0; i < 3000 && errors < 20; i++) begin
            checkAll("rand", !m_buf_valid, m_fetch_pc, m_buf_valid, m_inst, m_inst_pc, m_mis);
            a  = !m_buf_valid && ($urandom_range(0, 99) < 40);
            r  = ($urandom_range(0, 99) < 60);
            d  = ($urandom_range(0, 99) < 15);
            rp = $urandom;
            if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
            applyStimulus(a, $urandom, r, d, rp);
            modelStep(a, imem_rdata, r, d, rp);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Parametrised instruction-fetch stage for the next-generation MIPS core. It owns the PC, issues requests to an instruction memory with variable wait-states, and buffers one fetched instruction behind a valid/ready handshake to decode. It also accepts redirects (branch, jump, JAL, JR targets) from execute, including while a memory request is in flight.

## Interface
Parameters:
- ADDR_W, 32, PC and instruction-address width.
- INST_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset (ADDR_W bits, word aligned).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch address; valid while imem_req=1.
- imem_ack  in  1  memory response; imem_rdata is valid in the same cycle.
- imem_rdata  in  INST_W  fetched instruction.
- inst_valid  out  1  inst/inst_pc/inst_pc4 hold a valid instruction.
- inst_ready  in  1  decode accepts the instruction this cycle.
- inst  out  INST_W  buffered instruction.
- inst_pc  out  ADDR_W  address of inst.
- inst_pc4  out  ADDR_W  inst_pc+4, the JAL link value.
- redirect  in  1  replace the fetch stream.
- redirect_pc  in  ADDR_W  redirect target.
- misaligned  out  1  rejected-redirect pulse (see Configuration).

## Operation
- Internal registers: state, pc, tgt (pending redirect target), output buffer (inst, inst_pc, inst_valid).
- States: FETCH, HOLD, DROP.
- FETCH: imem_req=1, imem_addr=pc.
  - ack & !redirect: load buffer with imem_rdata and pc, set inst_valid, pc<=pc+4, go to HOLD.
  - ack & redirect: discard data, pc<=redirect_pc, stay in FETCH.
  - !ack & redirect: tgt<=redirect_pc, go to DROP. Address stays stable.
  - Neither ack nor redirect: stay in FETCH.
- HOLD: imem_req=0, inst_valid=1.
  - inst_ready & !redirect: clear inst_valid, go to FETCH.
  - redirect, with or without inst_ready: clear inst_valid, pc<=redirect_pc, go to FETCH. A coincident inst_ready counts as a completed handshake.
- DROP: imem_req=1, imem_addr=pc (the old address), inst_valid=0.
  - redirect: tgt<=redirect_pc, so the latest redirect wins.
  - ack: discard data, pc<=(redirect ? redirect_pc : tgt), go to FETCH.
- imem_req, once asserted, stays high with a constant imem_addr until imem_ack. Redirect never retracts a request.
- inst, inst_pc and inst_valid are stable while inst_valid=1 & !inst_ready.
- Arithmetic: pc+4 and inst_pc4 wrap modulo 2^ADDR_W. imem_addr[1:0] is always 00.

## Timing
- Reset values: state=FETCH, pc=RESET_PC, tgt=0, inst_valid=0, inst=0, inst_pc=0, misaligned=0. imem_req=0 while reset=1.
- imem_req and imem_addr are decoded from state and pc with no input-to-output combinational path. inst_pc4 is combinational from inst_pc.
- Latency with a zero-wait memory:
  - ack in cycle n gives inst_valid=1 in cycle n+1.
  - Peak throughput is one instruction per 2 cycles.
  - Each memory wait-state adds one cycle.
- Redirect to first valid instruction at the target, zero-wait memory:
  - From HOLD or FETCH: 2 cycles.
  - From DROP: remaining wait of the old request + 2 cycles.
- Reset asserted mid-request abandons the request. Memory must tolerate a dropped request with no ack consumed.

## Configuration
- MIPS_FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0]!=00 is rejected; state, pc and tgt are unchanged, as if redirect=0.
  - misaligned pulses high for exactly one cycle, on the cycle after the rejected redirect.
- MIPS_FETCH_ALIGN_CHECK_EN undefined:
  - redirect_pc[1:0] is forced to 00 and the redirect proceeds.
  - misaligned is tied to 0.

## Structure
- Shared package mips_pkg: fetch_state_t enum (FETCH, HOLD, DROP), PC_INC=4, default widths.
- No sub-module. The PC incrementer and output buffer are inline in one always block plus output decode.

## Test plan
- Reset with RESET_PC=0x100, zero-wait ack, inst_ready=1:
  - imem_addr sequence 0x100, 0x104, 0x108, one request every 2 cycles.
  - inst_pc4 equals 0x104 when inst_pc=0x100.
- 3 wait-states per fetch, inst_ready held 0 for 5 cycles in HOLD:
  - inst/inst_pc stay stable throughout.
  - imem_req stays 0 until ready.
- Redirect to 0x400 during FETCH with no ack, ack 2 cycles later:
  - imem_addr stays at the old pc until ack, then that data is discarded.
  - The next request is to 0x400 and the first delivered inst_pc is 0x400.
- Two redirects in DROP (0x200, then 0x300): the next fetch is to 0x300.
- Redirect to 0x500 in HOLD coincident with inst_ready: inst_valid drops, next imem_addr=0x500.
- With MIPS_FETCH_ALIGN_CHECK_EN, redirect to 0x402:
  - misaligned pulses for 1 cycle and the sequential stream continues.
  - Without the macro, the next fetch is at 0x400.
- Wrap-around with ADDR_W=32, pc=0xFFFFFFFC: inst_pc4=0x00000000 and the next fetch is at 0x0.
